// File: rtl/fft_stage_sequencer_if.sv
// Handshake and address bundle between the FFT stage sequencer and the
// sample RAM, twiddle ROM and butterfly datapath it controls.
interface fft_stage_sequencer_if #(
    parameter int unsigned LOG2N = 4
);
    logic             start;
    logic             busy;
    logic             done;
    logic [LOG2N-1:0] stage;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             bf_en;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;

    modport master (
        input  start,
        output busy, done, stage,
        output rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output bf_en, wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, stage,
        input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  bf_en, wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT controller: walks LOG2N stages issuing one butterfly
// per cycle, with a 2-cycle drain between stages and a 2-deep write-back pipeline.
module fft_stage_sequencer #(
    parameter int unsigned LOG2N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_stage_sequencer_if.master bus
);
    localparam int unsigned KW = LOG2N - 1;
    localparam logic [KW-1:0]    KLast     = {KW{1'b1}};
    localparam logic [KW-1:0]    KOne      = KW'(1);
    localparam logic [LOG2N-1:0] One       = LOG2N'(1);
    localparam logic [LOG2N-1:0] StageLast = LOG2N'(LOG2N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [KW-1:0]    k_q, k_d;
    logic             drain_q, drain_d;
    logic             done_q, done_d;

    logic             rd_en_q, rd_en_d;
    logic [LOG2N-1:0] rd_a_q, rd_a_d;
    logic [LOG2N-1:0] rd_b_q, rd_b_d;
    logic [KW-1:0]    tw_q, tw_d;

    logic             bf_en_q, wr_en_q;
    logic [LOG2N-1:0] mid_a_q, mid_b_q;
    logic [LOG2N-1:0] wr_a_q, wr_b_q;

    // Butterfly to issue this cycle; addresses are registered so they line up with rd_en.
    logic             issue;
    logic [LOG2N-1:0] iss_stage;
    logic [KW-1:0]    iss_k;

    logic [LOG2N-1:0] kx, half, pos, grp, addr_a, tw_full;

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        k_d       = k_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        iss_stage = stage_q;
        iss_k     = k_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StRun;
                    issue     = 1'b1;
                    iss_stage = '0;
                    iss_k     = '0;
                end
            end
            StRun: begin
                if (k_q == KLast) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end else begin
                    issue = 1'b1;
                    iss_k = k_q + KOne;
                end
            end
            StDrain: begin
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else if (stage_q != StageLast) begin
                    state_d   = StRun;
                    issue     = 1'b1;
                    iss_stage = stage_q + One;
                    iss_k     = '0;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            stage_d = iss_stage;
            k_d     = iss_k;
        end
    end

    // half = 2^s, pos = k mod half, group = k >> s; A = group*2*half + pos, B = A + half.
    always_comb begin
        kx      = {1'b0, iss_k};
        half    = One << iss_stage;
        pos     = kx & (half - One);
        grp     = kx >> iss_stage;
        addr_a  = (grp << (iss_stage + One)) | pos;
        tw_full = pos << (StageLast - iss_stage);

        rd_en_d = issue;
        rd_a_d  = rd_a_q;
        rd_b_d  = rd_b_q;
        tw_d    = tw_q;
        if (issue) begin
            rd_a_d = addr_a;
            rd_b_d = addr_a + half;
            tw_d   = tw_full[KW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            stage_q <= '0;
            k_q     <= '0;
            drain_q <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
        end
    end

    // Write-back pipeline never stalls; addresses only move with their valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bf_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            mid_a_q <= '0;
            mid_b_q <= '0;
            wr_a_q  <= '0;
            wr_b_q  <= '0;
        end else begin
            bf_en_q <= rd_en_q;
            wr_en_q <= bf_en_q;
            if (rd_en_q) begin
                mid_a_q <= rd_a_q;
                mid_b_q <= rd_b_q;
            end
            if (bf_en_q) begin
                wr_a_q <= mid_a_q;
                wr_b_q <= mid_b_q;
            end
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.stage     = stage_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = rd_a_q;
    assign bus.rd_addr_b = rd_b_q;
    assign bus.tw_addr   = tw_q;
    assign bus.bf_en     = bf_en_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr_a = wr_a_q;
    assign bus.wr_addr_b = wr_b_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (LOG2N=4): hand-computed vector table
// plus a per-cycle reference model, stray start, and mid-transform reset.
module tb_fft_stage_sequencer;
    localparam int unsigned LOG2N = 4;
    localparam int N     = 16;
    localparam int HALFN = N / 2;
    localparam int P     = HALFN + 2;
    localparam int TOT   = LOG2N * P;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.LOG2N(LOG2N)) bus ();

    fft_stage_sequencer #(.LOG2N(LOG2N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int cyc;
        int rd_en;
        int stage;
        int a;
        int b;
        int tw;
        int busy;
        int done;
    } vec_t;

    vec_t vec[12];

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference read-side behaviour at cycle t relative to an accepted start from reset state.
    function automatic void model(input int t, output int re, output int s, output int a,
                                  output int b, output int tw);
        int tt, j, k, half, pos;
        if (t < 1) begin
            re = 0; s = 0; a = 0; b = 0; tw = 0;
            return;
        end
        tt   = (t > TOT) ? TOT : t;
        s    = (tt - 1) / P;
        j    = (tt - 1) % P;
        re   = (t <= TOT && j < HALFN) ? 1 : 0;
        k    = (j < HALFN) ? j : HALFN - 1;
        half = 1 << s;
        pos  = k % half;
        a    = (k / half) * 2 * half + pos;
        b    = a + half;
        tw   = pos * (HALFN / half);
    endfunction

    task automatic check_model(input int t);
        int re, s, a, b, tw, re1, s1, a1, b1, tw1, re2, s2, a2, b2, tw2;
        model(t, re, s, a, b, tw);
        model(t - 1, re1, s1, a1, b1, tw1);
        model(t - 2, re2, s2, a2, b2, tw2);
        chk("rd_en", t, int'(bus.rd_en), re);
        chk("stage", t, int'(bus.stage), s);
        chk("rd_addr_a", t, int'(bus.rd_addr_a), a);
        chk("rd_addr_b", t, int'(bus.rd_addr_b), b);
        chk("tw_addr", t, int'(bus.tw_addr), tw);
        chk("bf_en", t, int'(bus.bf_en), re1);
        chk("wr_en", t, int'(bus.wr_en), re2);
        chk("wr_addr_a", t, int'(bus.wr_addr_a), a2);
        chk("wr_addr_b", t, int'(bus.wr_addr_b), b2);
        chk("busy", t, int'(bus.busy), (t >= 1 && t <= TOT) ? 1 : 0);
        chk("done", t, int'(bus.done), (t == TOT + 1) ? 1 : 0);
    endtask

    // Full transform: cycle 0 is the start cycle; stray >= 0 pulses start again mid-run.
    task automatic run(input int stray);
        int wr_cnt = 0;
        for (int t = 0; t <= TOT + 5; t++) begin
            @(posedge clk);
            #1;
            bus.start = (t == 0 || t == stray);
            check_model(t);
            for (int i = 0; i < 12; i++) begin
                if (vec[i].cyc == t) begin
                    chk("vec_rd_en", t, int'(bus.rd_en), vec[i].rd_en);
                    chk("vec_stage", t, int'(bus.stage), vec[i].stage);
                    chk("vec_addr_a", t, int'(bus.rd_addr_a), vec[i].a);
                    chk("vec_addr_b", t, int'(bus.rd_addr_b), vec[i].b);
                    chk("vec_tw", t, int'(bus.tw_addr), vec[i].tw);
                    chk("vec_busy", t, int'(bus.busy), vec[i].busy);
                    chk("vec_done", t, int'(bus.done), vec[i].done);
                end
            end
            if (bus.wr_en) wr_cnt++;
        end
        bus.start = 1'b0;
        chk("wr_count", TOT + 5, wr_cnt, LOG2N * HALFN);
    endtask

    initial begin
        //        cyc rd stg  a   b  tw busy done
        vec[0]  = '{ 1, 1, 0,  0,  1, 0, 1, 0};
        vec[1]  = '{ 8, 1, 0, 14, 15, 0, 1, 0};
        vec[2]  = '{ 9, 0, 0, 14, 15, 0, 1, 0};
        vec[3]  = '{10, 0, 0, 14, 15, 0, 1, 0};
        vec[4]  = '{11, 1, 1,  0,  2, 0, 1, 0};
        vec[5]  = '{12, 1, 1,  1,  3, 4, 1, 0};
        vec[6]  = '{26, 1, 2,  9, 13, 2, 1, 0};
        vec[7]  = '{36, 1, 3,  5, 13, 5, 1, 0};
        vec[8]  = '{38, 1, 3,  7, 15, 7, 1, 0};
        vec[9]  = '{40, 0, 3,  7, 15, 7, 1, 0};
        vec[10] = '{41, 0, 3,  7, 15, 7, 0, 1};
        vec[11] = '{42, 0, 3,  7, 15, 7, 0, 0};

        bus.start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("idle_busy", i, int'(bus.busy), 0);
            chk("idle_done", i, int'(bus.done), 0);
            chk("idle_rd_en", i, int'(bus.rd_en), 0);
            chk("idle_bf_en", i, int'(bus.bf_en), 0);
            chk("idle_wr_en", i, int'(bus.wr_en), 0);
            chk("idle_stage", i, int'(bus.stage), 0);
            chk("idle_addr", i, int'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
                                      bus.wr_addr_a, bus.wr_addr_b}), 0);
        end

        // Transform with a stray start in cycle 15 that must be ignored.
        run(15);

        // Abort: reset in cycle 13 while reads are in flight.
        for (int t = 0; t <= 13; t++) begin
            @(posedge clk);
            #1;
            bus.start = (t == 0);
            rst = (t == 13);
        end
        for (int t = 14; t <= 19; t++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk("abort_busy", t, int'(bus.busy), 0);
            chk("abort_rd_en", t, int'(bus.rd_en), 0);
            chk("abort_bf_en", t, int'(bus.bf_en), 0);
            chk("abort_wr_en", t, int'(bus.wr_en), 0);
            chk("abort_stage", t, int'(bus.stage), 0);
            chk("abort_done", t, int'(bus.done), 0);
            chk("abort_addr", t, int'(bus.rd_addr_b), 0);
        end

        // Fresh start in cycle 20 must run a complete, correct transform.
        run(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Controller for an in-place radix-2 decimation-in-time FFT built around one shared butterfly unit and a dual-port sample RAM plus twiddle ROM. On `start` it walks all LOG2N stages and issues one butterfly per cycle: RAM read addresses, twiddle index, butterfly clock enable and delayed write-back addresses. It drains the pipeline between stages so every stage reads fully written results of the previous stage. The sample RAM must already hold its input in bit-reversed order.

## Interface
- `LOG2N`, 4, log2 of FFT length N (N = 2^LOG2N, N/2 butterflies per stage); legal range 2..12.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the final write-back.
- `stage`  out  LOG2N bits (clog2(LOG2N)+1 is enough; LOG2N keeps it simple)  index of the stage being read, 0..LOG2N-1.
- `rd_en`  out  1  read strobe to sample RAM (1-cycle synchronous read).
- `rd_addr_a`, `rd_addr_b`  out  LOG2N  butterfly A/B operand addresses.
- `tw_addr`  out  LOG2N-1  twiddle ROM index (1-cycle synchronous read).
- `bf_en`  out  1  butterfly enable; equals `rd_en` delayed 1 cycle.
- `wr_en`  out  1  write strobe for butterfly results; equals `rd_en` delayed 2 cycles.
- `wr_addr_a`, `wr_addr_b`  out  LOG2N  `rd_addr_a/b` delayed 2 cycles; X result to A, Y result to B.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: outputs quiescent. `start`=1 moves to RUN with stage=0, k=0.
- RUN: `rd_en`=1 every cycle. Butterfly counter k counts 0..N/2-1. At k=N/2-1, go to DRAIN.
- DRAIN: lasts exactly 2 cycles with `rd_en`=0. After it, if stage<LOG2N-1, increment stage, clear k and return to RUN. Otherwise go to IDLE and pulse `done`.
- Address rule for stage s and butterfly k:
  - half = 2^s, pos = k mod half, group = k >> s.
  - rd_addr_a = group·2·half + pos.
  - rd_addr_b = rd_addr_a + half.
  - tw_addr = pos << (LOG2N-1-s).
  - All values are unsigned and never overflow their widths.
- `bf_en`, `wr_en`, `wr_addr_a/b` come from a 2-deep valid/address shift pipeline. The pipeline advances every cycle; there is no stall.
- `start` while busy: ignored, no restart, no queueing.
- `rst` at any time:
  - State returns to IDLE; stage and k are cleared.
  - Pipeline valid bits are cleared, so no `wr_en` or `bf_en` appears after reset, even for reads in flight.
  - An aborted transform leaves RAM contents undefined.
- Reset values: busy=0, done=0, rd_en=0, bf_en=0, wr_en=0, stage=0, all addresses 0.
- Addresses are held at their last value when the matching strobe is low.

## Timing
- Cycle 0 = cycle in which `start` is sampled high in IDLE.
- Stage s reads occur in cycles 1+s·(N/2+2) through s·(N/2+2)+N/2.
- Read issued in cycle t gives `bf_en` in t+1 and `wr_en` in t+2.
- Each stage's final write lands in that stage's second DRAIN cycle. The next stage's first read is in the following cycle, so there is no read-after-write hazard with a write-first/read-after-edge RAM.
- Total transform length is LOG2N·(N/2+2) cycles. `done` pulses in cycle LOG2N·(N/2+2)+1, and `busy` falls in that same cycle.
- For LOG2N=4: reads 1–8, 11–18, 21–28, 31–38; last `wr_en` in cycle 40; done in cycle 41.
- Earliest back-to-back `start` is accepted in the `done` cycle; IDLE is entered on that edge.

## Test plan
- Reset, then hold idle 5 cycles -> all outputs 0, busy=0, no strobes.
- LOG2N=4, start in cycle 0:
  - Cycle 1: rd_addr (0,1), tw=0.
  - Cycle 8: rd_addr (14,15), tw=0.
  - Cycle 11: stage=1, rd_addr (0,2), tw=0.
  - Cycle 12: rd_addr (1,3), tw=4.
- Same run, later stages:
  - Stage 2 k=5: rd_addr (9,13), tw=2.
  - Stage 3 k=5 (cycle 36): rd_addr (5,13), tw=5.
  - done in cycle 41 only; busy high in cycles 1–40.
- Pipeline alignment:
  - Every cycle: bf_en(t)=rd_en(t-1), wr_en(t)=rd_en(t-2), wr_addr(t)=rd_addr(t-2).
  - rd_en low in cycles 9,10,19,20,29,30,39,40.
- start pulsed in cycle 15 during busy -> ignored; done still in cycle 41; exactly 32 wr_en pulses.
- rst asserted in cycle 13 (reads in flight) -> cycle 14 onward: IDLE, no wr_en/bf_en, stage=0. A new start in cycle 20 runs a full, correct 41-cycle transform.
